// File: rtl/tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NREQ requesters; also owns the baud divider.
// Optional WAIT abort on missing TxDone: define TX_SCHED_TIMEOUT_EN.
module tx_scheduler #(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned BAUD_DIV      = 5208,
    parameter int unsigned LOAD_HOLD     = 16,
    parameter int unsigned GAP_CYCLES    = 16,
    parameter int unsigned TIMEOUT_TICKS = 12
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [NREQ-1:0]     Req,
    input  logic [8*NREQ-1:0]   ReqData,
    output logic [NREQ-1:0]     Grant,
    output logic [7:0]          TxData,
    output logic                TxLoad,
    output logic                TxEnable,
    input  logic                TxDone,
    output logic                Busy,
    output logic                Timeout
);
    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DW   = $clog2(BAUD_DIV);
    localparam int unsigned CMAX = (LOAD_HOLD > GAP_CYCLES) ? LOAD_HOLD : GAP_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_GAP} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   div_q;
    logic            txen_q;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [7:0]      data_q, data_d;
    logic            load_q, load_d;
    logic            timeout_q, timeout_d;
`ifdef TX_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
`endif

    // First set request at or above the pointer, wrapping around.
    logic            win_found;
    logic [PW-1:0]   win_idx;
    int unsigned     idx;
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_found && Req[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = '0;
        data_d    = data_q;
        load_d    = load_q;
        timeout_d = 1'b0;
`ifdef TX_SCHED_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
`endif
        case (state_q)
            S_IDLE: if (win_found) begin
                state_d          = S_LOAD;
                grant_d[win_idx] = 1'b1;
                data_d           = ReqData[8*win_idx +: 8];
                load_d           = 1'b1;
                cnt_d            = '0;
                ptr_d            = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
            end
            S_LOAD: if (cnt_q == CW'(LOAD_HOLD-1)) begin
                state_d  = S_WAIT;
                load_d   = 1'b0;
                cnt_d    = '0;
`ifdef TX_SCHED_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            S_WAIT: if (TxDone) begin
                state_d = S_GAP;
                cnt_d   = '0;
`ifdef TX_SCHED_TIMEOUT_EN
            end else if (txen_q) begin
                // TxDone on the terminal tick takes the branch above, so no abort.
                if (to_cnt_q == TW'(TIMEOUT_TICKS-1)) begin
                    state_d   = S_GAP;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            S_GAP: if (cnt_q == CW'(GAP_CYCLES-1)) begin
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            data_q    <= 8'h00;
            load_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef TX_SCHED_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            load_q    <= load_d;
            timeout_q <= timeout_d;
`ifdef TX_SCHED_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end

    // Free-running baud divider, independent of the scheduler state.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            div_q  <= '0;
            txen_q <= 1'b0;
        end else begin
            txen_q <= (div_q == DW'(BAUD_DIV-1));
            div_q  <= (div_q == DW'(BAUD_DIV-1)) ? '0 : div_q + 1'b1;
        end
    end

    assign Grant    = grant_q;
    assign TxData   = data_q;
    assign TxLoad   = load_q;
    assign TxEnable = txen_q;
    assign Busy     = (state_q != S_IDLE);
`ifdef TX_SCHED_TIMEOUT_EN
    assign Timeout  = timeout_q;
`else
    assign Timeout  = 1'b0;
`endif
endmodule

// File: tb/tb_tx_scheduler.sv
// Bench for tx_scheduler: table of send vectors with a grant scoreboard, plus reset/timeout/spurious-done sequences.
module tb_tx_scheduler;
    localparam int NREQ = 4, BAUD_DIV = 8, LOAD_HOLD = 16, GAP_CYCLES = 16, TIMEOUT_TICKS = 12;

    logic Clock, Reset, TxDone;
    logic [NREQ-1:0] Req, Grant;
    logic [8*NREQ-1:0] ReqData;
    logic [7:0] TxData;
    logic TxLoad, TxEnable, Busy, Timeout;

    tx_scheduler #(.NREQ(NREQ), .BAUD_DIV(BAUD_DIV), .LOAD_HOLD(LOAD_HOLD),
                   .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .ReqData(ReqData), .Grant(Grant),
        .TxData(TxData), .TxLoad(TxLoad), .TxEnable(TxEnable), .TxDone(TxDone),
        .Busy(Busy), .Timeout(Timeout));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: {expected grant, expected byte} pushed when a request is driven.
    logic [11:0] exp_q[$];
    logic [11:0] sb_e;
    always @(negedge Clock) begin
        if (Reset && Grant !== '0) begin
            if (exp_q.size() == 0) chk("unexpected_grant", 32'(Grant), 32'd0);
            else begin
                sb_e = exp_q.pop_front();
                chk("grant", 32'(Grant), 32'(sb_e[11:8]));
                chk("txdata", 32'(TxData), 32'(sb_e[7:0]));
                chk("txload_at_grant", 32'(TxLoad), 32'd1);
            end
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  req_after;
        logic        spur;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_data;
    } vec_t;
    vec_t vecs[12];

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 600) begin @(negedge Clock); n++; end
        if (Busy) chk("idle_wait_expired", 32'(Busy), 32'd0);
    endtask

    task automatic wait_grant();
        int n = 0;
        do begin @(negedge Clock); n++; end while (Grant == '0 && n < 50);
        if (Grant == '0) chk("grant_wait_expired", 32'(Grant), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int n, loads;
        wait_idle();
        Req = v.req; ReqData = v.data;
        exp_q.push_back({v.exp_grant, v.exp_data});
        wait_grant();
        Req = v.req_after;
        loads = 0;
        while (TxLoad && loads < 100) begin
            TxDone = (v.spur && loads == 3);
            loads++;
            @(negedge Clock);
        end
        TxDone = 1'b0;
        chk("txload_len", 32'(loads), 32'(LOAD_HOLD));
        repeat (5) @(negedge Clock);
        chk("wait_hold", 32'(Busy), 32'd1);
        TxDone = 1'b1;
        n = 0;
        do begin @(negedge Clock); TxDone = 1'b0; n++; end while (Busy && n < 100);
        chk("done_to_idle", 32'(n), 32'(GAP_CYCLES + 1));
        chk("txdata_hold", 32'(TxData), 32'(v.exp_data));
    endtask

    initial begin
        int n, m, ticks;
        logic last_en, to_seen;
        vecs[0]  = '{4'hF, 32'hBEADDEEF, 4'hF, 1'b0, 4'b0001, 8'hEF};
        vecs[1]  = '{4'hF, 32'hBEADDEEF, 4'hF, 1'b1, 4'b0010, 8'hDE};
        vecs[2]  = '{4'hF, 32'hBEADDEEF, 4'hF, 1'b0, 4'b0100, 8'hAD};
        vecs[3]  = '{4'hF, 32'hBEADDEEF, 4'hF, 1'b0, 4'b1000, 8'hBE};
        vecs[4]  = '{4'hF, 32'hBEADDEEF, 4'h0, 1'b0, 4'b0001, 8'hEF};
        vecs[5]  = '{4'h4, 32'h44332211, 4'h0, 1'b0, 4'b0100, 8'h33};
        vecs[6]  = '{4'h5, 32'h5A6B7C8D, 4'h0, 1'b1, 4'b0001, 8'h8D};
        vecs[7]  = '{4'h5, 32'h5A6B7C8D, 4'h0, 1'b0, 4'b0100, 8'h6B};
        vecs[8]  = '{4'hA, 32'hC0FFEE01, 4'h0, 1'b0, 4'b1000, 8'hC0};
        vecs[9]  = '{4'hA, 32'hC0FFEE01, 4'h0, 1'b0, 4'b0010, 8'hEE};
        vecs[10] = '{4'h3, 32'h00007F80, 4'h0, 1'b0, 4'b0001, 8'h80};
        vecs[11] = '{4'h3, 32'h00007F80, 4'h0, 1'b0, 4'b0010, 8'h7F};

        Reset = 1'b0; Req = '0; ReqData = '0; TxDone = 1'b0;
        repeat (2) @(negedge Clock);
        chk("rst_outputs", 32'({Grant, TxData, TxLoad, TxEnable, Busy, Timeout}), 32'd0);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);

        // Reset in the middle of LOAD.
        Req = 4'b0001; ReqData = 32'h000000CE;
        exp_q.push_back({4'b0001, 8'hCE});
        wait_grant();
        Req = '0;
        repeat (3) @(negedge Clock);
        chk("midload_txload_pre", 32'(TxLoad), 32'd1);
        Reset = 1'b0;
        #1;
        chk("midload_txload", 32'(TxLoad), 32'd0);
        chk("midload_txdata", 32'(TxData), 32'd0);
        chk("midload_rest", 32'({Grant, TxEnable, Busy, Timeout}), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        n = 0;
        do begin @(negedge Clock); n++; end while (!TxEnable && n < 100);
        chk("first_txen", 32'(n), 32'(BAUD_DIV));
        @(negedge Clock);
        chk("txen_width", 32'(TxEnable), 32'd0);
        m = 1;
        while (!TxEnable && m < 100) begin @(negedge Clock); m++; end
        chk("txen_period", 32'(m), 32'(BAUD_DIV));

        // TxDone while idle must not start anything.
        TxDone = 1'b1;
        @(negedge Clock);
        TxDone = 1'b0;
        repeat (5) @(negedge Clock);
        chk("idle_spurious_done", 32'(Busy), 32'd0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // No TxDone: pointer is 2, so requester 1 wins after wrapping.
        wait_idle();
        Req = 4'b0010; ReqData = 32'h00005500;
        exp_q.push_back({4'b0010, 8'h55});
        wait_grant();
        Req = '0;
        n = 0;
        while (TxLoad && n < 100) begin @(negedge Clock); n++; end
`ifdef TX_SCHED_TIMEOUT_EN
        ticks = 0; n = 0; last_en = 1'b0;
        while (!Timeout && n < 400) begin
            if (TxEnable) ticks++;
            last_en = TxEnable;
            @(negedge Clock);
            n++;
        end
        chk("timeout_seen", 32'(Timeout), 32'd1);
        chk("timeout_ticks", 32'(ticks), 32'(TIMEOUT_TICKS));
        chk("timeout_after_tick", 32'(last_en), 32'd1);
        n = 0;
        do begin
            @(negedge Clock); n++;
            if (n == 1) chk("timeout_width", 32'(Timeout), 32'd0);
        end while (Busy && n < 100);
        chk("timeout_gap", 32'(n), 32'(GAP_CYCLES));
`else
        to_seen = 1'b0;
        repeat (200) begin
            @(negedge Clock);
            if (Timeout) to_seen = 1'b1;
        end
        chk("no_timeout_pulse", 32'(to_seen), 32'd0);
        chk("no_timeout_busy", 32'(Busy), 32'd1);
        TxDone = 1'b1;
        @(negedge Clock);
        TxDone = 1'b0;
        wait_idle();
`endif
        repeat (3) @(negedge Clock);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tx_scheduler.md
# tx_scheduler

Shares one UART transmitter (the `TX` shift block) among `NREQ` requesters. Round-robin arbitration picks a requester, captures its byte, and drives the transmitter's parallel-load and baud-enable inputs. It then waits for the character-done indication before a fixed inter-character gap. It also owns the baud-tick divider that paces the transmitter.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `BAUD_DIV`, 5208, clocks per baud tick (≥2)
- `LOAD_HOLD`, 16, cycles `TxLoad` is held high (≥1)
- `GAP_CYCLES`, 16, idle cycles between characters (≥1)
- `TIMEOUT_TICKS`, 12, baud ticks allowed in WAIT before abort (timeout build only)

Ports:
- `Clock`  in  1  single system clock, rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `Req`  in  NREQ  per-requester send request, level
- `ReqData`  in  8*NREQ  byte for requester i at bits [8i+7:8i]
- `Grant`  out  NREQ  one-cycle one-hot pulse: byte of requester i captured
- `TxData`  out  8  byte presented to transmitter
- `TxLoad`  out  1  parallel-load strobe to transmitter
- `TxEnable`  out  1  baud tick, one-cycle pulse every `BAUD_DIV` clocks
- `TxDone`  in  1  one-cycle pulse from transmitter: character finished
- `Busy`  out  1  high whenever state ≠ IDLE
- `Timeout`  out  1  one-cycle pulse on WAIT abort

## Operation
- Reset (`Reset`=0): state IDLE; `Grant`=0, `TxData`=8'h00, `TxLoad`=0, `TxEnable`=0, `Busy`=0, `Timeout`=0; RR pointer=0; divider=0; all counters=0.
- Divider: free-running 0..`BAUD_DIV`-1, independent of state; `TxEnable`=1 in the cycle after count `BAUD_DIV`-1.
- States:
  - IDLE: any `Req` bit set → LOAD.
  - LOAD: `TxLoad`=1 for exactly `LOAD_HOLD` cycles → WAIT.
  - WAIT: `TxDone` → GAP.
  - GAP: `GAP_CYCLES` cycles → IDLE.
- Arbitration on IDLE→LOAD: winner is the first set `Req` bit searching from the pointer upward, wrapping mod `NREQ`.
  - `TxData` ← that byte.
  - `Grant[winner]`=1 for one cycle.
  - Pointer ← (winner+1) mod `NREQ`.
- Requesters hold `Req` and data stable until `Grant`. `Req` still high after `Grant` is a new request. `Req` dropped before grant is simply not served.
- `TxData` holds its value until the next capture.
- `TxDone` outside WAIT is ignored.

## Timing
- `Req` seen in IDLE at edge N → at edge N+1: `Grant`, `TxLoad`=1 and `TxData` valid together. `TxLoad` stays high for edges N+1..N+`LOAD_HOLD`.
- `TxDone` in WAIT at edge M → GAP from M+1. IDLE at M+1+`GAP_CYCLES`. Earliest next `Grant` at M+2+`GAP_CYCLES`.
- Minimum request-to-request spacing for one requester: `LOAD_HOLD`+1+`GAP_CYCLES`+1 cycles plus transmit time.
- Multiple simultaneous requests: exactly one `Grant` bit per capture, never two.
- Async reset mid-character drops `TxLoad` immediately. The transmitter sees no completion; the system resets it in the same reset domain.

## Configuration
- `TX_SCHED_TIMEOUT_EN` defined:
  - WAIT counts `TxEnable` pulses.
  - If the count reaches `TIMEOUT_TICKS` without `TxDone`: `Timeout`=1 for one cycle, then → GAP.
  - `TxDone` and the terminal tick in the same cycle: `TxDone` wins, no `Timeout`.
  - The counter clears on entry to WAIT.
- Undefined: WAIT waits indefinitely, `Timeout` is tied 0, and there is no tick counter.

## Test plan
- Reset: `Reset`=0 mid-LOAD with `TxData`=8'hCE → all outputs 0 immediately. After release, first `TxEnable` comes `BAUD_DIV` clocks later.
- Single send: `Req`=4'b0001, byte 8'hCE → `Grant`=4'b0001 one cycle. `TxData`=8'hCE, `TxLoad` high 16 cycles. `TxDone` pulse → `Busy` falls 17 cycles later.
- Round-robin: all four `Req` held with bytes 8'hEF, 8'hDE, 8'hAD, 8'hBE, each `TxDone` returned → grant order 0,1,2,3,0, and `TxData` sequence matches.
- Wrap/skip: pointer=3, `Req`=4'b0101 → grant bit 0, then bit 2, pointer ends at 3.
- Timeout (macro on, `TIMEOUT_TICKS`=12): no `TxDone` → `Timeout` pulse one cycle after the 12th `TxEnable` in WAIT, then GAP then IDLE. Macro off → `Busy` stays high.
- Spurious `TxDone` during LOAD and IDLE → no state change, no `Grant`.
